// File: rtl/imem_loader.sv
// Streams a program into instruction memory while holding the processor in reset, then releases it.
// Writes land one cycle after acceptance; in_ready is high only while loading, so in_valid gaps simply stall.
module imem_loader #(
  parameter int ADDR_WIDTH  = 12,
  parameter int HOLD_CYCLES = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  output logic                  in_ready,
  output logic                  imem_wren,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [31:0]           imem_data,
  output logic                  proc_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  // HOLD_CYCLES must be at least 1.
  localparam int                  HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [HW-1:0]       HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic                  in_ready_q, in_ready_d;
  logic                  imem_wren_q, imem_wren_d;
  logic [ADDR_WIDTH-1:0] imem_address_q, imem_address_d;
  logic [31:0]           imem_data_q, imem_data_d;
  logic                  proc_reset_q, proc_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  legal_start;
  logic                  accept;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    wcnt_d         = wcnt_q;
    hold_d         = hold_q;
    imem_wren_d    = 1'b0;
    imem_address_d = imem_address_q;
    imem_data_d    = imem_data_q;
    done_d         = 1'b0;
    error_d        = error_q;
    legal_start    = (word_count != '0) && (word_count <= MAX_COUNT);
    accept         = in_valid && in_ready_q;

    case (state_q)
      IDLE, RUN: begin
        if (start) begin
          if (legal_start) begin
            state_d = LOAD;
            count_d = word_count;
            wcnt_d  = '0;
            error_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          imem_wren_d    = 1'b1;
          imem_address_d = wcnt_q[ADDR_WIDTH-1:0];
          imem_data_d    = in_data;
          wcnt_d         = wcnt_q + CNT_ONE;
          // in_ready drops on the same edge as the final acceptance.
          if ((wcnt_q + CNT_ONE) == count_q) begin
            state_d = HOLD;
            hold_d  = '0;
          end
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d   = (state_d == LOAD);
    busy_d       = (state_d == LOAD) || (state_d == HOLD);
    proc_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      wcnt_q         <= '0;
      hold_q         <= '0;
      in_ready_q     <= 1'b0;
      imem_wren_q    <= 1'b0;
      imem_address_q <= '0;
      imem_data_q    <= '0;
      proc_reset_q   <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      wcnt_q         <= wcnt_d;
      hold_q         <= hold_d;
      in_ready_q     <= in_ready_d;
      imem_wren_q    <= imem_wren_d;
      imem_address_q <= imem_address_d;
      imem_data_q    <= imem_data_d;
      proc_reset_q   <= proc_reset_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_wren    = imem_wren_q;
  assign imem_address = imem_address_q;
  assign imem_data    = imem_data_q;
  assign proc_reset   = proc_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: hand-written vector table, directed corner sequences, then random traffic
// compared every cycle against a transaction-level model of the loader.
module tb_imem_loader;
  localparam int AW    = 12;
  localparam int HC    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset, start, in_valid;
  logic [AW:0]   word_count;
  logic [31:0]   in_data;
  logic          in_ready, imem_wren, proc_reset, busy, done, error;
  logic [AW-1:0] imem_address;
  logic [31:0]   imem_data;

  imem_loader #(.ADDR_WIDTH(AW), .HOLD_CYCLES(HC)) dut (
    .clock(clock), .reset(reset), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_wren(imem_wren), .imem_address(imem_address), .imem_data(imem_data),
    .proc_reset(proc_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: program phase plus words/hold cycles remaining.
  typedef enum int {M_IDLE, M_LOAD, M_HOLD, M_RUN} mode_t;
  mode_t         m_mode;
  int            m_left, m_next, m_hold;
  logic          m_err;
  logic          e_wren, e_done, e_ad;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_data;
  logic [31:0]   model_mem [DEPTH];
  logic [31:0]   dut_mem   [DEPTH];
  int            wr_seen = 0;
  int            done_seen = 0;
  logic [AW-1:0] last_wr_addr;

  function automatic bit legal_count(input int n);
    return (n >= 1) && (n <= DEPTH);
  endfunction

  task automatic model_step(input logic r, input logic s, input int wc, input logic v, input logic [31:0] d);
    e_wren = 1'b0; e_done = 1'b0; e_ad = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_err = 1'b0; e_ad = 1'b1; e_addr = '0; e_data = '0;
    end else begin
      case (m_mode)
        M_IDLE, M_RUN: if (s) begin
          if (legal_count(wc)) begin
            m_mode = M_LOAD; m_left = wc; m_next = 0; m_err = 1'b0;
          end else begin
            m_err = 1'b1;
          end
        end
        M_LOAD: if (v) begin
          e_wren = 1'b1; e_ad = 1'b1; e_addr = m_next[AW-1:0]; e_data = d;
          model_mem[m_next] = d;
          m_next++; m_left--;
          if (m_left == 0) begin m_mode = M_HOLD; m_hold = HC; end
        end
        M_HOLD: begin
          m_hold--;
          if (m_hold == 0) begin m_mode = M_RUN; e_done = 1'b1; end
        end
        default: ;
      endcase
    end
  endtask

  // Bit order everywhere: {in_ready, imem_wren, proc_reset, busy, done, error}
  function automatic logic [5:0] exp_ctrl();
    return {m_mode == M_LOAD, e_wren, m_mode != M_RUN,
            (m_mode == M_LOAD) || (m_mode == M_HOLD), e_done, m_err};
  endfunction

  function automatic logic [5:0] dut_ctrl();
    return {in_ready, imem_wren, proc_reset, busy, done, error};
  endfunction

  task automatic observe();
    if (imem_wren === 1'b1) begin
      dut_mem[imem_address] = imem_data;
      wr_seen++;
      last_wr_addr = imem_address;
    end
    if (done === 1'b1) done_seen++;
  endtask

  task automatic drive(input logic r, input logic s, input int wc, input logic v, input logic [31:0] d);
    reset = r; start = s; word_count = wc[AW:0]; in_valid = v; in_data = d;
    model_step(r, s, wc, v, d);
  endtask

  task automatic tick(input logic r, input logic s, input int wc, input logic v, input logic [31:0] d);
    drive(r, s, wc, v, d);
    @(negedge clock);
    observe();
    check("ctrl{rdy,wren,prst,busy,done,err}", 32'(dut_ctrl()), 32'(exp_ctrl()));
    if (e_ad) begin
      check("imem_address", 32'(imem_address), 32'(e_addr));
      check("imem_data", imem_data, e_data);
    end
  endtask

  typedef struct {
    logic r, s; int wc; logic v; logic [31:0] d;
    logic [5:0] ctrl; logic ad; logic [AW-1:0] addr; logic [31:0] data;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input int wc, input logic v,
                              input logic [31:0] d, input logic [5:0] c, input logic ad,
                              input logic [AW-1:0] a, input logic [31:0] dat);
    vec_t t;
    t.r = r; t.s = s; t.wc = wc; t.v = v; t.d = d; t.ctrl = c; t.ad = ad; t.addr = a; t.data = dat;
    return t;
  endfunction

  initial begin
    vec_t tbl[$];
    int   base, i;

    for (int k = 0; k < DEPTH; k++) begin model_mem[k] = '0; dut_mem[k] = '0; end

    // Basic 3-word load, release, illegal counts in RUN and IDLE, ignored start in LOAD.
    tbl.push_back(mk(1, 0, 0,    0, 32'h0,        6'b001000, 1, 12'h000, 32'h0));
    tbl.push_back(mk(0, 1, 3,    0, 32'h0,        6'b101100, 0, 12'h000, 32'h0));
    tbl.push_back(mk(0, 0, 0,    1, 32'h20010005, 6'b111100, 1, 12'h000, 32'h20010005));
    tbl.push_back(mk(0, 0, 0,    1, 32'h20020007, 6'b111100, 1, 12'h001, 32'h20020007));
    tbl.push_back(mk(0, 0, 0,    1, 32'h00221820, 6'b011100, 1, 12'h002, 32'h00221820));
    tbl.push_back(mk(0, 0, 0,    0, 32'h0,        6'b001100, 0, 12'h000, 32'h0));
    tbl.push_back(mk(0, 0, 0,    0, 32'h0,        6'b001100, 0, 12'h000, 32'h0));
    tbl.push_back(mk(0, 0, 0,    0, 32'h0,        6'b001100, 0, 12'h000, 32'h0));
    tbl.push_back(mk(0, 0, 0,    0, 32'h0,        6'b001100, 0, 12'h000, 32'h0));
    tbl.push_back(mk(0, 0, 0,    0, 32'h0,        6'b000010, 0, 12'h000, 32'h0));
    tbl.push_back(mk(0, 0, 0,    0, 32'h0,        6'b000000, 0, 12'h000, 32'h0));
    tbl.push_back(mk(0, 1, 0,    0, 32'h0,        6'b000001, 0, 12'h000, 32'h0));
    tbl.push_back(mk(0, 1, 4097, 0, 32'h0,        6'b000001, 0, 12'h000, 32'h0));
    tbl.push_back(mk(1, 0, 0,    0, 32'h0,        6'b001000, 1, 12'h000, 32'h0));
    tbl.push_back(mk(0, 1, 0,    0, 32'h0,        6'b001001, 0, 12'h000, 32'h0));
    tbl.push_back(mk(0, 0, 0,    0, 32'h0,        6'b001001, 0, 12'h000, 32'h0));
    tbl.push_back(mk(0, 1, 4097, 0, 32'h0,        6'b001001, 0, 12'h000, 32'h0));
    tbl.push_back(mk(0, 1, 2,    0, 32'h0,        6'b101100, 0, 12'h000, 32'h0));
    tbl.push_back(mk(0, 1, 0,    0, 32'h0,        6'b101100, 0, 12'h000, 32'h0));
    tbl.push_back(mk(1, 0, 0,    0, 32'h0,        6'b001000, 1, 12'h000, 32'h0));

    foreach (tbl[n]) begin
      drive(tbl[n].r, tbl[n].s, tbl[n].wc, tbl[n].v, tbl[n].d);
      @(negedge clock);
      observe();
      check($sformatf("vec%0d_ctrl", n), 32'(dut_ctrl()), 32'(tbl[n].ctrl));
      if (tbl[n].ad) begin
        check($sformatf("vec%0d_addr", n), 32'(imem_address), 32'(tbl[n].addr));
        check($sformatf("vec%0d_data", n), imem_data, tbl[n].data);
      end
    end

    // Stalls between two words, with a start in LOAD that must be ignored.
    tick(1, 0, 0, 0, 0);
    base = wr_seen;
    tick(0, 1, 2, 0, 0);
    tick(0, 0, 0, 1, 32'hA5A5_0001);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 32'hA5A5_0002);
    for (i = 0; i < HC + 2; i++) tick(0, 0, 0, 0, 0);
    check("stall_writes", wr_seen - base, 2);

    // Full depth, with in_valid left high past the last word.
    tick(1, 0, 0, 0, 0);
    base = wr_seen;
    tick(0, 1, DEPTH, 0, 0);
    for (i = 0; i < DEPTH; i++) tick(0, 0, 0, 1, $urandom);
    check("full_last_addr", 32'(last_wr_addr), 32'(DEPTH - 1));
    for (i = 0; i < HC + 2; i++) tick(0, 0, 0, 1, $urandom);
    check("full_write_count", wr_seen - base, DEPTH);

    // Reset after 2 of 5 words, asserted together with a valid word; then a 1-word restart.
    tick(0, 1, 5, 0, 0);
    tick(0, 0, 0, 1, 32'h1111_0000);
    tick(0, 0, 0, 1, 32'h1111_0001);
    tick(1, 1, 3, 1, 32'h1111_0002);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 1, 0, 0);
    tick(0, 0, 0, 1, 32'h2222_0000);
    for (i = 0; i < HC + 1; i++) tick(0, 0, 0, 0, 0);

    // Reload from RUN.
    base = done_seen;
    tick(0, 1, 1, 0, 0);
    tick(0, 0, 0, 1, 32'h3333_0000);
    for (i = 0; i < HC + 1; i++) tick(0, 0, 0, 0, 0);
    check("reload_done_pulses", done_seen - base, 1);

    // Random traffic.
    for (i = 0; i < 3000; i++) begin
      int   wc;
      logic r, s, v;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 5) == 0);
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       wc = 0;
        1:       wc = DEPTH + 1 + $urandom_range(0, DEPTH - 2);
        default: wc = $urandom_range(1, 8);
      endcase
      tick(r, s, wc, v, $urandom);
    end

    begin
      int bad = 0;
      for (int k = 0; k < DEPTH; k++) if (dut_mem[k] !== model_mem[k]) bad++;
      check("imem_contents_mismatches", bad, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
